// File: rtl/conv_unit.sv
// rtl/conv_unit.sv - fp16 convolution unit: bias plus N-element dot product, one MAC per clock
module conv_unit #(
  parameter int data_width    = 16,
  parameter int input_channel = 2,
  parameter int weight_length = 3,
  parameter int weight_width  = 3
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic                                                          conv_en,
  input  logic [0:input_channel*weight_length*weight_width*data_width-1] image,
  input  logic [0:input_channel*weight_length*weight_width*data_width-1] weight,
  input  logic [15:0]                                                   bias,
  output logic [15:0]                                                   result,
  output logic                                                          cu_out_valid
);

  localparam int N  = input_channel * weight_length * weight_width;
  localparam int VW = N * data_width;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, next_state;
  logic [IW-1:0]   idx;
  logic [15:0]     acc;
  logic [0:VW-1]   img_q, w_q;
  logic [15:0]     img_e, w_e, prod, sum;
  logic            last;

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [21:0]       p;
    logic signed [7:0] e;
    logic [10:0]       m;
    logic              g, st;
    logic [11:0]       mr;
    logic [15:0]       r;
    s      = a[15] ^ b[15];
    nan_a  = (&a[14:10]) && (|a[9:0]);
    nan_b  = (&b[14:10]) && (|b[9:0]);
    inf_a  = (&a[14:10]) && !(|a[9:0]);
    inf_b  = (&b[14:10]) && !(|b[9:0]);
    zero_a = (a[14:10] == 5'd0);
    zero_b = (b[14:10] == 5'd0);
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15;
    if (p[21]) begin
      m  = p[21:11];
      g  = p[10];
      st = |p[9:0];
      e  = e + 8'sd1;
    end else begin
      m  = p[20:10];
      g  = p[9];
      st = |p[8:0];
    end
    mr = {1'b0, m} + {11'd0, g & (st | m[0])};
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 8'sd1;
    end
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
      r = 16'h7E00;
    else if (inf_a || inf_b)
      r = {s, 5'h1F, 10'h000};
    else if (zero_a || zero_b)
      r = {s, 15'h0000};
    else if (e >= 8'sd31)
      r = {s, 5'h1F, 10'h000};
    else if (e <= 8'sd0)
      r = {s, 15'h0000};
    else
      r = {s, e[4:0], mr[9:0]};
    return r;
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [15:0]       x, y, r;
    logic [4:0]        d;
    logic [13:0]       mx, my, sh, n;
    logic [14:0]       s15;
    logic signed [7:0] e;
    logic              st, found, g, s2;
    logic [3:0]        lz;
    logic [11:0]       mr;
    nan_a  = (&a[14:10]) && (|a[9:0]);
    nan_b  = (&b[14:10]) && (|b[9:0]);
    inf_a  = (&a[14:10]) && !(|a[9:0]);
    inf_b  = (&b[14:10]) && !(|b[9:0]);
    zero_a = (a[14:10] == 5'd0);
    zero_b = (b[14:10] == 5'd0);
    // x is the larger magnitude operand so the aligned difference is never negative
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[14:10] - y[14:10];
    mx = {1'b1, x[9:0], 3'b000};
    my = {1'b1, y[9:0], 3'b000};
    sh = my >> d;
    st = |(my & ~(14'h3FFF << d));
    sh[0] = sh[0] | st;
    e  = $signed({3'b0, x[14:10]});
    if (x[15] == y[15]) begin
      s15 = {1'b0, mx} + {1'b0, sh};
      if (s15[14]) begin
        n    = s15[14:1];
        n[0] = n[0] | s15[0];
        e    = e + 8'sd1;
      end else begin
        n = s15[13:0];
      end
    end else begin
      s15 = {1'b0, mx} - {1'b0, sh};
      n   = s15[13:0];
    end
    lz    = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && n[i]) begin
        lz    = 4'(13 - i);
        found = 1'b1;
      end
    end
    n  = n << lz;
    e  = e - $signed({4'b0, lz});
    g  = n[2];
    s2 = |n[1:0];
    mr = {1'b0, n[13:3]} + {11'd0, g & (s2 | n[3])};
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 8'sd1;
    end
    if (nan_a || nan_b || (inf_a && inf_b && (a[15] != b[15])))
      r = 16'h7E00;
    else if (inf_a)
      r = {a[15], 5'h1F, 10'h000};
    else if (inf_b)
      r = {b[15], 5'h1F, 10'h000};
    else if (zero_a && zero_b)
      r = (a[15] && b[15]) ? 16'h8000 : 16'h0000;
    else if (zero_a)
      r = b;
    else if (zero_b)
      r = a;
    else if (n == 14'd0)
      r = 16'h0000;
    else if (e >= 8'sd31)
      r = {x[15], 5'h1F, 10'h000};
    else if (e <= 8'sd0)
      r = {x[15], 15'h0000};
    else
      r = {x[15], e[4:0], mr[9:0]};
    return r;
  endfunction

  assign img_e = img_q[int'(idx)*data_width +: 16];
  assign w_e   = w_q[int'(idx)*data_width +: 16];
  assign prod  = fp16_mul(img_e, w_e);
  assign sum   = fp16_add(acc, prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    last       = 1'b0;
    case (state)
      IDLE: if (conv_en) next_state = RUN;
      RUN: begin
        if (idx == IW'(N - 1)) begin
          last       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      acc          <= 16'h0000;
      img_q        <= '0;
      w_q          <= '0;
      result       <= 16'h0000;
      cu_out_valid <= 1'b0;
    end else begin
      cu_out_valid <= last;
      case (state)
        IDLE: begin
          if (conv_en) begin
            img_q <= image;
            w_q   <= weight;
            acc   <= bias;
            idx   <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          if (last) begin
            result <= sum;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_unit.sv
// tb/tb_conv_unit.sv - directed table-driven bench for conv_unit
module tb_conv_unit;

  localparam int N  = 18;
  localparam int VW = N * 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            conv_en;
  logic [0:VW-1]   image, weight;
  logic [15:0]     bias;
  logic [15:0]     result;
  logic            cu_out_valid;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [15:0] iv;
    int          si;
    logic [15:0] sv;
    logic [15:0] wv;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[15];

  conv_unit dut (
    .clk(clk), .rst_n(rst_n), .conv_en(conv_en), .image(image), .weight(weight),
    .bias(bias), .result(result), .cu_out_valid(cu_out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic fill(input logic [15:0] v, input int si, input logic [15:0] sv,
                      output logic [0:VW-1] vec);
    for (int k = 0; k < N; k++) vec[k*16 +: 16] = (k == si) ? sv : v;
  endtask

  task automatic wait_pulse(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (cu_out_valid !== 1'b1 && cnt < 40);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (cu_out_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    int cnt, pulses;
    logic [0:VW-1] tmp;

    tbl[0]  = '{"ones",     16'h3C00, -1, 16'h0000, 16'h3C00, 16'h3C00, 16'h4CC0};
    tbl[1]  = '{"twos",     16'h4000, -1, 16'h0000, 16'h3C00, 16'h3C00, 16'h50A0};
    tbl[2]  = '{"neg",      16'h3C00, -1, 16'h0000, 16'hBC00, 16'h3C00, 16'hCC40};
    tbl[3]  = '{"zero_img", 16'h0000, -1, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00};
    tbl[4]  = '{"inf_x0",   16'h0000,  5, 16'h7C00, 16'h0000, 16'h3C00, 16'h7E00};
    tbl[5]  = '{"overflow", 16'h7800, -1, 16'h0000, 16'h3C00, 16'h0000, 16'h7C00};
    tbl[6]  = '{"tie_even", 16'h0000,  0, 16'h1000, 16'h3C00, 16'h3C00, 16'h3C00};
    tbl[7]  = '{"tie_up",   16'h0000,  0, 16'h1000, 16'h3C00, 16'h3C01, 16'h3C02};
    tbl[8]  = '{"pos_zero", 16'h0000, -1, 16'h0000, 16'h3C00, 16'h8000, 16'h0000};
    tbl[9]  = '{"neg_zero", 16'h0000, -1, 16'h0000, 16'hBC00, 16'h8000, 16'h8000};
    tbl[10] = '{"subnorm",  16'h0001, -1, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00};
    tbl[11] = '{"halves",   16'h3800, -1, 16'h0000, 16'h4000, 16'h0000, 16'h4C80};
    tbl[12] = '{"cancel",   16'h0000,  0, 16'hBC00, 16'h3C00, 16'h3C00, 16'h0000};
    tbl[13] = '{"nan_in",   16'h3C00, 17, 16'h7D00, 16'h3C00, 16'h0000, 16'h7E00};
    tbl[14] = '{"inf_ninf", 16'h0000,  3, 16'hFC00, 16'h3C00, 16'h7C00, 16'h7E00};

    rst_n   = 1'b0;
    conv_en = 1'b0;
    image   = '0;
    weight  = '0;
    bias    = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_result", {16'h0, result}, 32'h0);
    check("reset_valid", {31'h0, cu_out_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", {31'h0, cu_out_valid}, 32'h0);

    // back-to-back with conv_en held high
    fill(16'h3C00, -1, 16'h0, tmp); image = tmp;
    fill(16'h3C00, -1, 16'h0, tmp); weight = tmp;
    bias = 16'h3C00;
    conv_en = 1'b1;
    @(negedge clk);
    wait_pulse(cnt);
    check("b2b_lat1", cnt, 32'd18);
    check("b2b_res1", {16'h0, result}, 32'h4CC0);
    fill(16'h4000, -1, 16'h0, tmp); image = tmp;
    wait_pulse(cnt);
    check("b2b_period", cnt, 32'd19);
    check("b2b_res2", {16'h0, result}, 32'h50A0);
    conv_en = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 15; t++) begin
      fill(tbl[t].iv, tbl[t].si, tbl[t].sv, tmp); image = tmp;
      fill(tbl[t].wv, -1, 16'h0, tmp); weight = tmp;
      bias = tbl[t].b;
      conv_en = 1'b1;
      @(negedge clk);
      conv_en = 1'b0;
      for (int k = 0; k < N; k++) begin
        image[k*16 +: 16]  = 16'($urandom);
        weight[k*16 +: 16] = 16'($urandom);
      end
      bias = 16'($urandom);
      wait_pulse(cnt);
      check({tbl[t].name, "_lat"}, cnt, 32'd18);
      check({tbl[t].name, "_res"}, {16'h0, result}, {16'h0, tbl[t].exp});
      @(negedge clk);
      check({tbl[t].name, "_pulse"}, {31'h0, cu_out_valid}, 32'h0);
    end

    // no new capture with conv_en low, result holds
    count_pulses(30, pulses);
    check("hold_pulses", pulses, 32'd0);
    check("hold_result", {16'h0, result}, 32'h7E00);

    // asynchronous reset in the middle of a run
    fill(16'h3C00, -1, 16'h0, tmp); image = tmp; weight = tmp;
    bias = 16'h3C00;
    conv_en = 1'b1;
    @(negedge clk);
    conv_en = 1'b0;
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_result", {16'h0, result}, 32'h0);
    check("midrst_valid", {31'h0, cu_out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(40, pulses);
    check("midrst_no_pulse", pulses, 32'd0);
    check("midrst_hold", {16'h0, result}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
